cgra_config_loader: RTL and testbench

Configuration sequencer that sits directly upstream of the CGRA `top`. It accepts (address, data) configuration words from a word source over a valid/ready handshake and presents each word on the CGRA's `config_addr_in`/`config_data_in` for a fixed hold window. It holds the CGRA in reset for the whole configuration phase, then releases reset and flags completion so the data phase can begin.

---
 rtl/cgra_config_loader.sv | 155 +++++++++++++++
 tb/tb_cgra_config_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_config_loader.sv
// Configuration sequencer ahead of the CGRA: streams (addr,data) words onto the config bus, then releases CGRA reset.
// Optional build macro CFG_CHECKSUM_EN adds checksum_out, a running sum of (addr ^ data) over the delivered words.
module cgra_config_loader #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                HOLD_CYCLES   = 2,
  parameter int                SETTLE_CYCLES = 4,
  parameter logic [ADDR_W-1:0] END_ADDR      = '1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic              word_valid_in,
  input  logic [ADDR_W-1:0] word_addr_in,
  input  logic [DATA_W-1:0] word_data_in,
  output logic              word_ready_out,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              cgra_reset_out,
  output logic              config_done_out,
  output logic [15:0]       word_count_out,
  output logic              error_out
`ifdef CFG_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum_out
`endif
);

  // state  | meaning
  // IDLE   | waiting for start_in
  // WAIT   | ready for the next word
  // HOLD   | driving an accepted word to the CGRA
  // SETTLE | end marker seen, CGRA still held in reset
  // DONE   | CGRA released and running
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_SETTLE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              crst_q, crst_d;
  logic              done_q, done_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  logic              accept, is_end, start_ok;

  assign accept   = (state_q == S_WAIT) && ready_q && word_valid_in;
  assign is_end   = (word_addr_in == END_ADDR);
  assign start_ok = (state_q == S_IDLE) && start_in;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      crst_q  <= 1'b1;
      done_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      crst_q  <= crst_d;
      done_q  <= done_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // The counter is loaded so that HOLD/SETTLE exit on the edge the timing requires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start_in) state_d = S_WAIT;
      S_WAIT: begin
        if (accept) begin
          if (is_end) begin
            state_d = S_SETTLE;
            cnt_d   = 8'(SETTLE_CYCLES);
          end else begin
            state_d = S_HOLD;
            cnt_d   = 8'(HOLD_CYCLES - 1);
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) state_d = S_WAIT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready stays low on the start edge itself, so the first word is taken one cycle later.
  always_comb begin
    ready_d = (state_d == S_WAIT) && (state_q != S_IDLE);
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept && !is_end) begin
      addr_d = word_addr_in;
      data_d = word_data_in;
    end else if (state_d != S_HOLD) begin
      addr_d = '0;
      data_d = '0;
    end
    crst_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    count_d = count_q;
    if (start_ok)
      count_d = '0;
    else if (accept && !is_end && (count_q != 16'hFFFF))
      count_d = count_q + 16'd1;
    err_d = err_q | (start_in && (state_q != S_IDLE));
  end

  assign word_ready_out  = ready_q;
  assign config_addr_out = addr_q;
  assign config_data_out = data_q;
  assign cgra_reset_out  = crst_q;
  assign config_done_out = done_q;
  assign word_count_out  = count_q;
  assign error_out       = err_q;

`ifdef CFG_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_ok)
      sum_d = '0;
    else if (accept && !is_end)
      sum_d = sum_q + (DATA_W'(word_addr_in) ^ word_data_in);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) sum_q <= '0;
    else           sum_q <= sum_d;
  end

  assign checksum_out = sum_q;
`endif

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed self-checking bench for cgra_config_loader with default parameters (HOLD=2, SETTLE=4).
// Checksum checks are compiled in when CFG_CHECKSUM_EN is defined.
module tb_cgra_config_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        valid;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] caddr;
  logic [31:0] cdata;
  logic        crst;
  logic        done;
  logic [15:0] count;
  logic        err;
`ifdef CFG_CHECKSUM_EN
  logic [31:0] csum;
  logic [31:0] exp_sum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] END_W = 32'hFFFF_FFFF;

  cgra_config_loader dut (
    .clk_in          (clk),
    .reset_in        (reset_n),
    .start_in        (start),
    .word_valid_in   (valid),
    .word_addr_in    (waddr),
    .word_data_in    (wdata),
    .word_ready_out  (ready),
    .config_addr_out (caddr),
    .config_data_out (cdata),
    .cgra_reset_out  (crst),
    .config_done_out (done),
    .word_count_out  (count),
    .error_out       (err)
`ifdef CFG_CHECKSUM_EN
    ,
    .checksum_out    (csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
    chk({tag, "_addr"},  caddr, 32'd0);
    chk({tag, "_data"},  cdata, 32'd0);
    chk({tag, "_crst"},  {31'd0, crst}, 32'd1);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_count"}, {16'd0, count}, 32'd0);
    chk({tag, "_err"},   {31'd0, err}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    valid   = 1'b0;
    tick();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_edge_ready", {31'd0, ready}, 32'd0);
    chk("start_count_clr", {16'd0, count}, 32'd0);
    tick();
    chk("start_next_ready", {31'd0, ready}, 32'd1);
`ifdef CFG_CHECKSUM_EN
    exp_sum = 32'd0;
    chk("start_csum_clr", csum, 32'd0);
`endif
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (!ready && budget < 20) begin
      tick();
      budget++;
    end
    chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d,
                           input logic [15:0] exp_cnt, input bit bubble, input bit start_mid);
    if (bubble) begin
      valid = 1'b0;
      tick();
      chk("bubble_gap_addr", caddr, 32'd0);
    end
    valid = 1'b1;
    waddr = a;
    wdata = d;
    wait_ready();
    tick();
    if (bubble) valid = 1'b0;
    chk("acc_addr",  caddr, a);
    chk("acc_data",  cdata, d);
    chk("acc_count", {16'd0, count}, {16'd0, exp_cnt});
    chk("acc_ready", {31'd0, ready}, 32'd0);
`ifdef CFG_CHECKSUM_EN
    exp_sum = exp_sum + (a ^ d);
    chk("acc_csum", csum, exp_sum);
`endif
    if (start_mid) start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_addr", caddr, a);
    chk("hold_data", cdata, d);
    if (start_mid) chk("mid_start_err", {31'd0, err}, 32'd1);
    tick();
    chk("gap_addr",  caddr, 32'd0);
    chk("gap_data",  cdata, 32'd0);
    chk("gap_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic send_end(input logic [15:0] exp_cnt);
    valid = 1'b1;
    waddr = END_W;
    wdata = 32'hDEAD_BEEF;
    wait_ready();
    tick();
    valid = 1'b0;
    chk("end_ready", {31'd0, ready}, 32'd0);
    chk("end_addr",  caddr, 32'd0);
    chk("end_crst",  {31'd0, crst}, 32'd1);
    chk("end_count", {16'd0, count}, {16'd0, exp_cnt});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("settle_done", {31'd0, done}, 32'd0);
      chk("settle_crst", {31'd0, crst}, 32'd1);
    end
    tick();
    chk("done_flag",  {31'd0, done}, 32'd1);
    chk("done_crst",  {31'd0, crst}, 32'd0);
    chk("done_count", {16'd0, count}, {16'd0, exp_cnt});
    chk("done_addr",  caddr, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    valid   = 1'b0;
    waddr   = 32'd0;
    wdata   = 32'd0;
`ifdef CFG_CHECKSUM_EN
    exp_sum = 32'd0;
`endif
    tick();
    tick();
    tick();
    chk_reset_vals("por");
    reset_n = 1'b1;
    tick();
    chk("idle_ready", {31'd0, ready}, 32'd0);

    // Always-valid source, two words
    do_start();
    send_word(32'h10, 32'h5, 16'd1, 1'b0, 1'b0);
    send_word(32'h20, 32'h7, 16'd2, 1'b0, 1'b0);
    send_end(16'd2);
    chk("t1_err", {31'd0, err}, 32'd0);
`ifdef CFG_CHECKSUM_EN
    chk("t1_csum", csum, 32'h3C);
`endif

    // Bubbly source, three words
    do_reset();
    do_start();
    send_word(32'h1, 32'hA, 16'd1, 1'b1, 1'b0);
    send_word(32'h2, 32'hB, 16'd2, 1'b1, 1'b0);
    send_word(32'h3, 32'hC, 16'd3, 1'b1, 1'b0);
    send_end(16'd3);
    chk("t2_err", {31'd0, err}, 32'd0);

    // start_in during HOLD: sticky error, pass still completes
    do_reset();
    do_start();
    send_word(32'h30, 32'h1, 16'd1, 1'b0, 1'b0);
    send_word(32'h31, 32'h2, 16'd2, 1'b0, 1'b1);
    chk("t3_err_sticky", {31'd0, err}, 32'd1);
    send_end(16'd2);
    chk("t3_err_end", {31'd0, err}, 32'd1);

    // Reset during HOLD of word 2, then full reload
    do_reset();
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    do_start();
    send_word(32'h40, 32'h11, 16'd1, 1'b0, 1'b0);
    valid = 1'b1;
    waddr = 32'h41;
    wdata = 32'h22;
    tick();
    chk("t4_hold_addr", caddr, 32'h41);
    reset_n = 1'b0;
    valid   = 1'b0;
    tick();
    chk_reset_vals("midrst");
    reset_n = 1'b1;
    tick();
    do_start();
    send_word(32'h40, 32'h11, 16'd1, 1'b0, 1'b0);
    send_word(32'h41, 32'h22, 16'd2, 1'b0, 1'b0);
    send_end(16'd2);

    // Immediate END, then start while DONE
    do_reset();
    do_start();
    send_end(16'd0);
    chk("t5_err", {31'd0, err}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_err",  {31'd0, err}, 32'd1);
    chk("done_start_stay", {31'd0, done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
